// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding and
// latency-counter width.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_port_align.sv
// Combinational lane logic: request legality, byte enables, store steering
// and load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic        legal,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rword,
    output logic [31:0] ld_data
);

    logic       aligned;
    logic       f3_load_ok;
    logic       f3_store_ok;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        aligned     = 1'b0;
        f3_load_ok  = 1'b0;
        f3_store_ok = 1'b0;
        case (funct3)
            F3_B, F3_BU: aligned = 1'b1;
            F3_H, F3_HU: aligned = ~offset[0];
            F3_W:        aligned = (offset == 2'b00);
            default:     aligned = 1'b0;
        endcase
        case (funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_load_ok = 1'b1;
            default:                        f3_load_ok = 1'b0;
        endcase
        case (funct3)
            F3_B, F3_H, F3_W: f3_store_ok = 1'b1;
            default:          f3_store_ok = 1'b0;
        endcase
        legal = aligned & ((req_load & ~req_store & f3_load_ok) |
                           (req_store & ~req_load & f3_store_ok));
    end

    // Only meaningful for legal stores; funct3[1:0] gives the access size.
    always_comb begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel = rword[{ld_offset, 3'b000} +: 8];
        half_sel = ld_offset[1] ? rword[31:16] : rword[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'b0, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'b0, half_sel};
            default: ld_data = rword;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Multi-cycle load/store unit between the ALU and a synchronous word-wide
// data memory port; stalls the core through ready while a request is in flight.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready=1, waiting for a request
// ST_ISSUE | one-cycle memory strobe (mem_ren for loads, mem_we for stores)
// ST_WAIT  | counting down read latency, capture extracted data at zero
// ST_RESP  | done pulse with rdata/err valid
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_ren,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

    lsu_state_e       state;
    lsu_state_e       state_nxt;
    logic             accept;
    logic             is_load_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [3:0]       be_q;
    logic [CNT_W-1:0] cnt_q;

    logic             legal;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_lane;
    logic [31:0]      ld_data;

    assign accept = ready & req_valid;

    lsu_align u_align (
        .req_load   (req_load),
        .req_store  (req_store),
        .funct3     (req_funct3),
        .offset     (req_addr[1:0]),
        .wdata      (req_wdata),
        .legal      (legal),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .ld_funct3  (f3_q),
        .ld_offset  (off_q),
        .rword      (mem_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = legal ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: state_nxt = is_load_q ? ST_WAIT : ST_RESP;
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready   = (state == ST_IDLE);
        done    = (state == ST_RESP);
        mem_ren = (state == ST_ISSUE) & is_load_q;
        mem_we  = ((state == ST_ISSUE) & ~is_load_q) ? be_q : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_load_q <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            be_q      <= 4'b0000;
            cnt_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                is_load_q <= req_load;
                f3_q      <= req_funct3;
                off_q     <= req_addr[1:0];
                be_q      <= byte_en;
                mem_addr  <= req_addr[ADDR_W-1:2];
                mem_wdata <= wdata_lane;
                err       <= ~legal;
                if (!legal) begin
                    rdata <= '0;
                end
            end
            if ((state == ST_ISSUE) && is_load_q) begin
                cnt_q <= CNT_LOAD;
            end
            // mem_rdata is only trusted on the cycle the counter reaches zero.
            if (state == ST_WAIT) begin
                if (cnt_q == '0) begin
                    rdata <= ld_data;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Multi-cycle load/store unit on the consumer side of the ALU.
- Takes the ALU's effective address and the store data (rs2), drives a synchronous word-wide data BRAM/MMIO port, and returns aligned, sign/zero-extended load data to the register writeback path.
- The core stalls on ready=0.
- Supports RV32I lb/lh/lw/lbu/lhu/sb/sh/sw.

Parameters:
- ADDR_W, 32, byte-address width; the memory word address is ADDR_W-2 bits.
- READ_LAT, 1, memory read latency in cycles from the mem_ren cycle to the cycle mem_rdata is valid; legal range 1..4.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core request; sampled only when ready=1
- req_load  in  1  request is a load
- req_store  in  1  request is a store
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- ready  out  1  unit idle, request can be accepted
- done  out  1  one-cycle completion pulse
- rdata  out  32  extracted load result, valid with done
- err  out  1  misaligned or illegal request, valid with done
- mem_addr  out  ADDR_W-2  word address
- mem_ren  out  1  read strobe, one cycle
- mem_we  out  4  byte write enables, one cycle
- mem_wdata  out  32  lane-steered store data
- mem_rdata  in  32  read word

Behaviour:
- Clock, reset and accept
  - Reset: all outputs 0 except ready=1; FSM goes to IDLE. The reset is asynchronous, so it also drops mem_ren/mem_we mid-cycle.
  - Accept: at rising edge T when ready & req_valid. The unit latches funct3, addr[1:0], word address and steered wdata.
  - req_valid while ready=0 is ignored; the core holds the request.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE (ready=1)
  - Legal load → ISSUE.
  - Legal store → ISSUE.
  - Illegal request → RESP with err.
- ISSUE
  - Load: mem_ren=1 and mem_addr valid; the latency counter is loaded with READ_LAT-1 → WAIT.
  - Store: mem_we = byte enables and mem_wdata valid → RESP.
- WAIT
  - Counter decrements each cycle.
  - When the counter is 0 and mem_rdata is valid, register the extracted value → RESP.
- RESP: done=1 for exactly one cycle, rdata/err valid → IDLE. ready returns to 1 in the cycle after RESP.
- Latency, counting the cycle after edge T as cycle 1:
  - Load: done in cycle READ_LAT+2.
  - Store: done in cycle 2.
  - Error: done in cycle 1.
- Alignment
  - lw/sw require addr[1:0]=0.
  - lh/lhu/sh require addr[0]=0.
  - Byte ops are always aligned.
- Illegal requests → err=1, rdata=0, no memory strobe. Illegal means any of:
  - misaligned address;
  - load funct3 not in {000,001,010,100,101};
  - store funct3 not in {000,001,010};
  - req_load & req_store both set;
  - neither req_load nor req_store set.
- Load extract, with o=addr[1:0]:
  - lb: sign-extend byte o (bits 8o+7:8o).
  - lbu: zero-extend byte o.
  - lh: sign-extend half o[1].
  - lhu: zero-extend half o[1].
  - lw: the full word.
- Store steer
  - sb: wdata[7:0] replicated to all 4 lanes, mem_we = 1<<o.
  - sh: wdata[15:0] replicated to both halves, mem_we = 0011 or 1100.
  - sw: mem_we = 1111.
- Outputs
  - mem_ren/mem_we are 0 in every state except ISSUE.
  - mem_addr/mem_wdata hold their last value otherwise (don't-care).
  - rdata holds its value until the next done.
  - err is cleared on every accept.
- Reset mid-operation: an in-flight read is abandoned and a late mem_rdata is ignored. No done is produced for the aborted request.
- Store followed immediately by a load to the same word: the store's write strobe precedes the load's read strobe by at least 2 cycles, so no bypass is needed.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - FSM state encoding (2-bit: IDLE, ISSUE, WAIT, RESP);
  - the latency-counter width (3 bits).
- Sub-module lsu_align (combinational) holds:
  - legality/alignment check;
  - byte-enable generation;
  - store lane steering;
  - load extract/sign-extension.
- The top level keeps the FSM, counter and registers.

Test Plan:
- lb, addr 0x0000_0103, mem word 0x80FF_1234, READ_LAT=1 → mem_ren with mem_addr=0x40; done in cycle 3 with rdata=0xFFFF_FF80, err=0.
- lbu then lhu, same word, addr 0x102 → 0x0000_00FF; then 0x0000_80FF.
- sh, addr 0x0000_0202, wdata 0x1234_ABCD → in cycle 1: mem_we=1100, mem_wdata=0xABCD_ABCD, mem_addr=0x80; done in cycle 2.
- lw at addr 0x0000_0006 → done in cycle 1 with err=1, rdata=0, mem_ren never asserted; sw with funct3=011 → same result.
- READ_LAT=3 lw, addr 0x10, followed back-to-back by sw → done at cycle 5; ready=0 during cycles 1-5; the sw is accepted at the first edge with ready=1, and no request is lost or duplicated.
- rst_n pulsed low during WAIT of a lw → outputs 0 immediately, ready=1 after release, no done pulse; the next lb completes normally.
